// File: rtl/cv32e40x_bch_predictor_if.sv
// cv32e40x_bch_predictor_if: ID/EX-facing signal bundle of the branch target and direction predictor.
package cv32e40x_bch_pkg;
  typedef enum logic [1:0] {
    CT_NONE = 2'b00,
    CT_JAL  = 2'b01,
    CT_JALR = 2'b10,
    CT_BCH  = 2'b11
  } bch_jmp_mux_e;
endpackage

interface cv32e40x_bch_predictor_if;
  import cv32e40x_bch_pkg::*;
  bch_jmp_mux_e bch_jmp_mux_sel_i;
  logic [31:0]  pc_id_i;
  logic [31:0]  imm_uj_type_i;
  logic [31:0]  imm_sb_type_i;
  logic [31:0]  imm_i_type_i;
  logic [31:0]  jalr_fw_i;
  logic [31:0]  bch_target_o;
  logic [31:0]  jmp_target_o;
  logic         bch_prediction_id_o;
  logic         upd_valid_i;
  logic [31:0]  upd_pc_i;
  logic         upd_taken_i;
  logic         upd_pred_i;
  logic         flush_i;
  logic         mispredict_o;
  logic [31:0]  mispredict_cnt_o;
  modport master (
    output bch_jmp_mux_sel_i, pc_id_i, imm_uj_type_i, imm_sb_type_i, imm_i_type_i, jalr_fw_i,
           upd_valid_i, upd_pc_i, upd_taken_i, upd_pred_i, flush_i,
    input  bch_target_o, jmp_target_o, bch_prediction_id_o, mispredict_o, mispredict_cnt_o
  );
  modport slave (
    input  bch_jmp_mux_sel_i, pc_id_i, imm_uj_type_i, imm_sb_type_i, imm_i_type_i, jalr_fw_i,
           upd_valid_i, upd_pc_i, upd_taken_i, upd_pred_i, flush_i,
    output bch_target_o, jmp_target_o, bch_prediction_id_o, mispredict_o, mispredict_cnt_o
  );
endinterface

// File: rtl/cv32e40x_bch_predictor.sv
// cv32e40x_bch_predictor: ID-stage jump/branch target adder with a saturating-counter
// direction predictor trained from EX, plus misprediction pulse and saturating count.
module cv32e40x_bch_predictor
  import cv32e40x_bch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int DYNAMIC = 1
) (
  input logic                      clk,
  input logic                      rst,
  cv32e40x_bch_predictor_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  logic [CNT_W-1:0] r_tbl [ENTRIES];
  logic             r_mis;
  logic [31:0]      r_mis_cnt;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_up_idx;
  logic [CNT_W-1:0] w_cur;
  logic [CNT_W-1:0] w_next;
  logic [31:0]      w_tgt;
  logic             w_is_bch;
  logic             w_mis;
  logic             w_unused;
  assign w_rd_idx = bus.pc_id_i[IDX_W:1];
  assign w_up_idx = bus.upd_pc_i[IDX_W:1];
  assign w_is_bch = bus.bch_jmp_mux_sel_i == CT_BCH;
  assign w_tgt = bus.bch_jmp_mux_sel_i == CT_JAL ? bus.pc_id_i + bus.imm_uj_type_i :
                 w_is_bch ? bus.pc_id_i + bus.imm_sb_type_i :
                 (bus.jalr_fw_i + bus.imm_i_type_i) & ~32'd1;
  assign bus.bch_target_o = w_tgt;
  assign bus.jmp_target_o = w_tgt;
  // Static mode keys off the immediate sign so a wrapping target cannot flip the guess
  assign bus.bch_prediction_id_o = w_is_bch &&
    (DYNAMIC != 0 ? r_tbl[w_rd_idx][CNT_W-1] : bus.imm_sb_type_i[31]);
  assign w_cur  = r_tbl[w_up_idx];
  assign w_next = bus.upd_taken_i ? (&w_cur ? w_cur : w_cur + 1'b1)
                                  : (|w_cur ? w_cur - 1'b1 : w_cur);
  assign w_mis  = bus.upd_valid_i && (bus.upd_taken_i != bus.upd_pred_i);
  assign bus.mispredict_o     = r_mis;
  assign bus.mispredict_cnt_o = r_mis_cnt;
  assign w_unused = ^{bus.pc_id_i[31:IDX_W+1], bus.pc_id_i[0],
                      bus.upd_pc_i[31:IDX_W+1], bus.upd_pc_i[0]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= CNT_INIT;
    end else if (bus.flush_i) begin
      for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= CNT_INIT;
    end else if (bus.upd_valid_i) begin
      r_tbl[w_up_idx] <= w_next;
    end
  end
  // Flush clears only the table; the misprediction statistics survive it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mis     <= 1'b0;
      r_mis_cnt <= '0;
    end else begin
      r_mis     <= w_mis;
      r_mis_cnt <= r_mis_cnt + {31'd0, w_mis & ~&r_mis_cnt};
    end
  end
endmodule

// File: tb/tb_cv32e40x_bch_predictor.sv
// tb_cv32e40x_bch_predictor: directed and randomized checks of targets, prediction, training
// and misprediction accounting against a counter-array reference model.
module tb_cv32e40x_bch_predictor;
  import cv32e40x_bch_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int unsigned mdl [16];
  int unsigned mcnt;
  cv32e40x_bch_predictor_if bd ();
  cv32e40x_bch_predictor_if bs ();
  cv32e40x_bch_predictor #(.ENTRIES(16), .CNT_W(2), .DYNAMIC(1)) dut   (.clk(clk), .rst(rst), .bus(bd));
  cv32e40x_bch_predictor #(.ENTRIES(16), .CNT_W(2), .DYNAMIC(0)) dut_s (.clk(clk), .rst(rst), .bus(bs));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic mdl_reset();
    foreach (mdl[i]) mdl[i] = 1;
  endtask
  function automatic logic mdl_pred(input logic [31:0] pc);
    return mdl[pc[4:1]] >= 2;
  endfunction
  task automatic drive(input bch_jmp_mux_e sel, input logic [31:0] pc, uj, sb, ii, fw);
    bd.bch_jmp_mux_sel_i = sel; bs.bch_jmp_mux_sel_i = sel;
    bd.pc_id_i = pc;            bs.pc_id_i = pc;
    bd.imm_uj_type_i = uj;      bs.imm_uj_type_i = uj;
    bd.imm_sb_type_i = sb;      bs.imm_sb_type_i = sb;
    bd.imm_i_type_i = ii;       bs.imm_i_type_i = ii;
    bd.jalr_fw_i = fw;          bs.jalr_fw_i = fw;
  endtask
  task automatic upd_set(input logic v, input logic [31:0] pc, input logic t, p, f);
    bd.upd_valid_i = v; bs.upd_valid_i = v;
    bd.upd_pc_i = pc;   bs.upd_pc_i = pc;
    bd.upd_taken_i = t; bs.upd_taken_i = t;
    bd.upd_pred_i = p;  bs.upd_pred_i = p;
    bd.flush_i = f;     bs.flush_i = f;
  endtask
  task automatic tick();
    logic v, t, p, f;
    logic [31:0] pc;
    @(posedge clk);
    v = bd.upd_valid_i; t = bd.upd_taken_i; p = bd.upd_pred_i; f = bd.flush_i; pc = bd.upd_pc_i;
    if (v && t != p && mcnt != 32'hFFFF_FFFF) mcnt++;
    if (f) mdl_reset();
    else if (v) mdl[pc[4:1]] = t ? (mdl[pc[4:1]] == 3 ? 3 : mdl[pc[4:1]] + 1)
                                 : (mdl[pc[4:1]] == 0 ? 0 : mdl[pc[4:1]] - 1);
    #1;
  endtask
  task automatic upd(input logic [31:0] pc, input logic t, p);
    upd_set(1'b1, pc, t, p, 1'b0);
    tick();
    upd_set(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    logic [31:0] pc, uj, sb, ii, fw, exp_t;
    bch_jmp_mux_e sel;
    logic v, t, p, f, em;
    mdl_reset();
    mcnt = 0;
    upd_set(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    drive(CT_BCH, 32'h100, 32'd0, 32'h10, 32'd0, 32'd0);
    #3;
    chk("pred_in_reset", 32'(bd.bch_prediction_id_o), 32'd0);
    chk("mis_in_reset", 32'(bd.mispredict_o), 32'd0);
    chk("cnt_in_reset", bd.mispredict_cnt_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(CT_JAL, 32'h0000_1000, 32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'd0, 32'd0);
    #1;
    chk("jal_bch_tgt", bd.bch_target_o, 32'h0000_0FF0);
    chk("jal_jmp_tgt", bd.jmp_target_o, 32'h0000_0FF0);
    chk("jal_pred_static", 32'(bs.bch_prediction_id_o), 32'd0);
    chk("jal_pred_dyn", 32'(bd.bch_prediction_id_o), 32'd0);
    drive(CT_JALR, 32'h0, 32'd0, 32'd0, 32'h4, 32'h2001);
    #1;
    chk("jalr_tgt", bd.jmp_target_o, 32'h2004);
    drive(CT_BCH, 32'hFFFF_FFFC, 32'd0, 32'h8, 32'd0, 32'd0);
    #1;
    chk("bch_wrap_tgt", bd.bch_target_o, 32'h4);
    chk("bch_wrap_static", 32'(bs.bch_prediction_id_o), 32'd0);
    drive(CT_BCH, 32'h200, 32'd0, 32'hFFFF_FFF8, 32'd0, 32'd0);
    #1;
    chk("static_backward", 32'(bs.bch_prediction_id_o), 32'd1);
    drive(CT_BCH, 32'h200, 32'd0, 32'h10, 32'd0, 32'd0);
    #1;
    chk("static_forward", 32'(bs.bch_prediction_id_o), 32'd0);
    drive(CT_BCH, 32'h100, 32'd0, 32'h10, 32'd0, 32'd0);
    #1;
    chk("train_init", 32'(bd.bch_prediction_id_o), 32'd0);
    upd_set(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    #1;
    chk("same_cycle_old", 32'(bd.bch_prediction_id_o), 32'd0);
    tick();
    upd_set(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("same_cycle_new", 32'(bd.bch_prediction_id_o), 32'd1);
    chk("mis_pulse_train", 32'(bd.mispredict_o), 32'd1);
    for (int i = 0; i < 3; i++) upd(32'h100, 1'b1, 1'b1);
    upd(32'h100, 1'b0, 1'b1);
    chk("sat_then_dec", 32'(bd.bch_prediction_id_o), 32'd1);
    upd(32'h100, 1'b0, 1'b0);
    upd(32'h100, 1'b0, 1'b0);
    chk("trained_nt", 32'(bd.bch_prediction_id_o), 32'd0);
    chk("trained_nt_mdl", 32'(bd.bch_prediction_id_o), 32'(mdl_pred(32'h100)));
    upd(32'h120, 1'b1, 1'b0);
    upd(32'h120, 1'b1, 1'b0);
    chk("alias_pred", 32'(bd.bch_prediction_id_o), 32'd1);
    chk("alias_mis", 32'(bd.mispredict_o), 32'd1);
    chk("alias_cnt", bd.mispredict_cnt_o, 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mis", 32'(bd.mispredict_o), 32'd0);
    chk("async_rst_cnt", bd.mispredict_cnt_o, 32'd0);
    chk("async_rst_pred", 32'(bd.bch_prediction_id_o), 32'd0);
    mdl_reset();
    mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      t = 1'($urandom);
      upd(32'h0A, t, i < 5 ? ~t : t);
      chk("mis_pulse", 32'(bd.mispredict_o), 32'(i < 5));
      chk("mis_cnt", bd.mispredict_cnt_o, mcnt);
      tick();
      chk("mis_clear", 32'(bd.mispredict_o), 32'd0);
    end
    chk("mis_cnt_five", bd.mispredict_cnt_o, 32'd5);
    drive(CT_BCH, 32'h0, 32'd0, 32'h10, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) upd(32'h0, 1'b1, 1'b1);
    chk("flush_pre", 32'(bd.bch_prediction_id_o), 32'd1);
    upd_set(1'b1, 32'h0, 1'b1, 1'b1, 1'b1);
    tick();
    upd_set(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("flush_pred", 32'(bd.bch_prediction_id_o), 32'd0);
    chk("flush_cnt", bd.mispredict_cnt_o, 32'd5);
    upd(32'h0, 1'b1, 1'b1);
    chk("flush_weak_nt", 32'(bd.bch_prediction_id_o), 32'd1);
    @(negedge clk);
    force dut.r_mis_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_mis_cnt;
    mcnt = 32'hFFFF_FFFE;
    upd(32'h40, 1'b1, 1'b0);
    chk("cnt_reach_max", bd.mispredict_cnt_o, 32'hFFFF_FFFF);
    upd(32'h40, 1'b0, 1'b1);
    chk("cnt_hold_max", bd.mispredict_cnt_o, 32'hFFFF_FFFF);
    mcnt = 0;
    rst = 1'b1;
    #1;
    mdl_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      sel = bch_jmp_mux_e'(2'($urandom_range(0, 3)));
      pc = $urandom; uj = $urandom; sb = $urandom; ii = $urandom; fw = $urandom;
      v = 1'($urandom); t = 1'($urandom); p = 1'($urandom); f = ($urandom_range(0, 15) == 0);
      drive(sel, pc, uj, sb, ii, fw);
      upd_set(v, $urandom_range(0, 1) ? pc : $urandom, t, p, f);
      #1;
      exp_t = sel == CT_JAL ? pc + uj : sel == CT_BCH ? pc + sb : (fw + ii) & 32'hFFFF_FFFE;
      chk("rnd_bch_tgt", bd.bch_target_o, exp_t);
      chk("rnd_jmp_tgt", bd.jmp_target_o, exp_t);
      chk("rnd_pred_dyn", 32'(bd.bch_prediction_id_o), 32'(sel == CT_BCH && mdl_pred(pc)));
      chk("rnd_pred_static", 32'(bs.bch_prediction_id_o), 32'(sel == CT_BCH && sb[31]));
      em = v && t != p;
      tick();
      chk("rnd_mis", 32'(bd.mispredict_o), 32'(em));
      chk("rnd_cnt", bd.mispredict_cnt_o, mcnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cv32e40x_bch_predictor.md
# cv32e40x_bch_predictor

Parametrised successor to the ID-stage PC target adder. Computes JAL/JALR/branch targets combinationally and adds a dynamic branch direction predictor: a table of saturating counters indexed by PC, trained by branch resolution from EX, with a static backward-taken/forward-not-taken (BTFN) mode. Also tracks mispredictions. Sits in ID, feeding the IF-stage redirect logic. EX feeds it resolved branch outcomes.

## Interface
Parameters:
- ENTRIES, 16: number of predictor counters. Power of two, range 2..1024. IDX_W = log2(ENTRIES).
- CNT_W, 2: counter width in bits, range 1..4.
- DYNAMIC, 1: 1 selects table prediction; 0 selects static BTFN (table still trains).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- bch_jmp_mux_sel_i  in  bch_jmp_mux_e  CT_JAL / CT_BCH / CT_JALR selector
- pc_id_i  in  32  PC of the instruction in ID
- imm_uj_type_i, imm_sb_type_i, imm_i_type_i  in  32 each  sign-extended immediates
- jalr_fw_i  in  32  forwarded rs1 for JALR
- bch_target_o  out  32  branch target
- jmp_target_o  out  32  jump target
- bch_prediction_id_o  out  1  predicted taken for the CT_BCH instruction in ID
- upd_valid_i  in  1  EX resolved a conditional branch this cycle
- upd_pc_i  in  32  PC of the resolved branch
- upd_taken_i  in  1  actual outcome
- upd_pred_i  in  1  prediction that was made for it
- flush_i  in  1  synchronous clear of the predictor table
- mispredict_o  out  1  registered; high for one cycle after a mispredicted update
- mispredict_cnt_o  out  32  saturating count of mispredictions

## Operation
- Target selection is combinational and applies in every mode:
  - CT_JAL: pc_id_i + imm_uj_type_i.
  - CT_BCH: pc_id_i + imm_sb_type_i.
  - CT_JALR and default: (jalr_fw_i + imm_i_type_i) with bit 0 forced to 0.
  - All sums are mod 2^32 and wrap silently.
  - bch_target_o and jmp_target_o carry the same value.
- Index mapping: idx(pc) = pc[IDX_W:1]. Bit 1 is included so compressed instructions get distinct entries.
- Prediction when sel == CT_BCH:
  - DYNAMIC=1: predicted taken = MSB of counter[idx(pc_id_i)].
  - DYNAMIC=0: predicted taken = imm_sb_type_i[31], i.e. a backward branch. The decision uses the immediate sign, not an address compare, so wrap-around cannot flip it.
- When sel != CT_BCH, bch_prediction_id_o = 0.
- Counter update on upd_valid_i:
  - Target entry is counter[idx(upd_pc_i)].
  - Increments if upd_taken_i, decrements otherwise.
  - Saturates at 2^CNT_W-1 and at 0.
- Table reset value (on rst or flush_i): every counter = 2^(CNT_W-1)-1, weakly not-taken. For CNT_W=1 this is 0.
- Priority: rst > flush_i > update. An update in the same cycle as flush_i is dropped.
- Misprediction:
  - Detected when upd_valid_i and upd_taken_i != upd_pred_i.
  - mispredict_o is set next cycle for one cycle.
  - mispredict_cnt_o increments, holding at 0xFFFF_FFFF.
  - flush_i does not clear the counter. Only rst does.

## Timing
- Targets and bch_prediction_id_o: zero latency, purely combinational from inputs and current table state.
- Update becomes visible to prediction from the cycle after upd_valid_i.
- Same-cycle read and write of the same index: the read returns the old value. There is no bypass.
- mispredict_o: 1-cycle latency after upd_valid_i.
- Reset values: table at weakly not-taken, mispredict_o = 0, mispredict_cnt_o = 0.
- Combinational outputs follow the inputs during reset. A predict output read during reset reflects the reset table.
- Reset asserted mid-training: the table returns to the reset value immediately (asynchronous). An update in that cycle is lost.
- No handshake. EX must present each resolution exactly once, with upd_valid_i held for one cycle.

## Test plan
- Targets:
  - CT_JAL, pc=0x0000_1000, imm_uj=0xFFFF_FFF0 -> 0x0000_0FF0.
  - CT_JALR, rs1=0x2001, imm_i=0x4 -> 0x2004 (bit 0 cleared).
  - CT_BCH, pc=0xFFFF_FFFC, imm_sb=0x8 -> 0x0000_0004 (wrap).
- Static mode (DYNAMIC=0):
  - imm_sb=0xFFFF_FFF8 -> prediction 1.
  - imm_sb=0x10 -> prediction 0.
  - CT_JAL with any immediate -> prediction 0.
- Training (DYNAMIC=1, CNT_W=2):
  - After reset, pc=0x100 predicts 0.
  - One taken update on 0x100 -> next cycle predicts 1.
  - Three more taken updates, then one not-taken -> still 1 (counter saturated at 3, now 2).
  - Two more not-taken -> 0.
- Aliasing and same-cycle read/write (ENTRIES=16):
  - Updates to 0x100 and 0x120 hit the same entry, because bits [4:1] are equal.
  - Update 0x100 taken while ID reads pc=0x100 in the same cycle -> old prediction 0 that cycle, 1 the next.
- Misprediction counting:
  - Five updates with taken != pred, one with taken == pred -> mispredict_o pulses five times, one cycle after each; mispredict_cnt_o = 5.
  - Force the counter to 0xFFFF_FFFF, then mispredict -> holds at 0xFFFF_FFFF.
- Flush and reset:
  - Train idx 0 to 3, then assert flush_i together with a taken update to idx 0 -> next cycle counter = 1, prediction 0, count unchanged.
  - Assert rst asynchronously mid-cycle -> all outputs at reset values before the next edge.
